// File: rtl/op_share_arb.sv
// op_share_arb: round-robin time-sharing of one fixed-latency operator
// among P requesters, with tag tracking and result routing.
module op_share_arb #(
   parameter  int N  = 16,
   parameter  int P  = 4,
   parameter  int L  = 1,
   localparam int TW = $clog2(P)
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           EN,
   input  logic [P-1:0]   REQ_R,
   input  logic [P*N-1:0] REQ_D,
   output logic [P-1:0]   ACK,
   output logic           OP_EN,
   output logic           OP_R_IN,
   output logic [N-1:0]   OP_D_IN,
   input  logic           OP_R_OUT,
   input  logic [N-1:0]   OP_D_OUT,
   output logic [P-1:0]   RSP_R,
   output logic [N-1:0]   RSP_D,
   output logic           ERR
);

   // Tag stage 0 rides alongside OP_R_IN; stage L lines up with OP_R_OUT.
   logic [TW-1:0] ptr_q, ptr_d;
   logic          op_r_q, op_r_d;
   logic [N-1:0]  op_d_q, op_d_d;
   logic [L:0]    tv_q, tv_d;
   logic [TW-1:0] tid_q [L+1];
   logic [TW-1:0] tid_d [L+1];
   logic          err_q, err_d;

   logic          found;
   logic          grant;
   logic [TW-1:0] win;
   logic [TW-1:0] idx;

   // Find the first pending requester at or after the pointer.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < P; k++) begin
         idx = TW'((int'(ptr_q) + k) % P);
         if (!found && REQ_R[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign grant = EN && !RST && found;

   // One-hot grant to the winner while enabled.
   always_comb begin
      ACK = '0;
      if (grant) ACK[win] = 1'b1;
   end

   // Next-state logic; EN low freezes everything.
   always_comb begin
      ptr_d  = ptr_q;
      op_r_d = op_r_q;
      op_d_d = op_d_q;
      tv_d   = tv_q;
      tid_d  = tid_q;
      err_d  = err_q;
      if (EN) begin
         op_r_d = grant;
         tv_d   = {tv_q[L-1:0], grant};
         tid_d[0] = win;
         for (int k = 1; k <= L; k++) tid_d[k] = tid_q[k-1];
         if (grant) begin
            op_d_d = REQ_D[int'(win)*N +: N];
            if (win == TW'(P-1)) ptr_d = '0;
            else                 ptr_d = win + TW'(1);
         end
         if (OP_R_OUT && !tv_q[L]) err_d = 1'b1;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ptr_q  <= '0;
         op_r_q <= 1'b0;
         op_d_q <= '0;
         tv_q   <= '0;
         tid_q  <= '{default: '0};
         err_q  <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         op_r_q <= op_r_d;
         op_d_q <= op_d_d;
         tv_q   <= tv_d;
         tid_q  <= tid_d;
         err_q  <= err_d;
      end
   end

   // Route a returning result to the requester whose tag reached stage L.
   always_comb begin
      RSP_R = '0;
      if (OP_R_OUT && tv_q[L]) RSP_R[tid_q[L]] = 1'b1;
   end

   assign RSP_D   = OP_D_OUT;
   assign OP_EN   = EN;
   assign OP_R_IN = op_r_q;
   assign OP_D_IN = op_d_q;
   assign ERR     = err_q;

endmodule

// File: tb/tb_op_share_arb.sv
// tb_op_share_arb: randomized and directed checks of op_share_arb
// against a queue-based reference model and a behavioural operator.
module tb_op_share_arb;
   localparam int N = 16;
   localparam int P = 4;
   localparam int L = 3;

   logic           CLK = 1'b0;
   logic           RST;
   logic           EN;
   logic [P-1:0]   REQ_R;
   logic [P*N-1:0] REQ_D;
   logic [P-1:0]   ACK;
   logic           OP_EN;
   logic           OP_R_IN;
   logic [N-1:0]   OP_D_IN;
   logic           OP_R_OUT;
   logic [N-1:0]   OP_D_OUT;
   logic [P-1:0]   RSP_R;
   logic [N-1:0]   RSP_D;
   logic           ERR;

   op_share_arb #(.N(N), .P(P), .L(L)) dut (
      .CLK(CLK), .RST(RST), .EN(EN),
      .REQ_R(REQ_R), .REQ_D(REQ_D), .ACK(ACK),
      .OP_EN(OP_EN), .OP_R_IN(OP_R_IN), .OP_D_IN(OP_D_IN),
      .OP_R_OUT(OP_R_OUT), .OP_D_OUT(OP_D_OUT),
      .RSP_R(RSP_R), .RSP_D(RSP_D), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   // Behavioural shared operator: latency L, result = bitwise NOT of input.
   logic [L-1:0] opv;
   logic [N-1:0] opd [L];
   logic         spur;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         opv <= '0;
         for (int i = 0; i < L; i++) opd[i] <= '0;
      end else if (OP_EN) begin
         opv <= {opv[L-2:0], OP_R_IN};
         opd[0] <= ~OP_D_IN;
         for (int i = 1; i < L; i++) opd[i] <= opd[i-1];
      end
   end

   assign OP_R_OUT = opv[L-1] | spur;
   assign OP_D_OUT = opd[L-1];

   // Reference model state.
   typedef struct {
      int          id;
      logic [N-1:0] d;
      int          t;
   } txn_t;

   txn_t q[$];
   int   mptr;
   int   en_cnt;
   bit   exp_err;
   int   total;
   int   passed;

   // One clock: check at negedge, advance model at posedge.
   task automatic tick();
      logic [P-1:0] exp_ack;
      logic [P-1:0] exp_rsp;
      logic [N-1:0] exp_d;
      int w;
      @(negedge CLK);
      exp_ack = '0;
      exp_rsp = '0;
      exp_d   = '0;
      w = -1;
      if (EN) begin
         for (int k = 0; k < P; k++) begin
            int i;
            i = (mptr + k) % P;
            if (w < 0 && REQ_R[i]) w = i;
         end
      end
      if (w >= 0) exp_ack[w] = 1'b1;
      total++;
      if (ACK !== exp_ack)
         $display("FAIL ack: got %b want %b t=%0t", ACK, exp_ack, $time);
      else passed++;
      total++;
      if (OP_EN !== EN)
         $display("FAIL op_en: got %b want %b", OP_EN, EN);
      else passed++;
      if (EN) begin
         if (q.size() > 0 && en_cnt - q[0].t == L + 1) begin
            exp_rsp[q[0].id] = 1'b1;
            exp_d = q[0].d;
            q.pop_front();
         end
         total++;
         if (RSP_R !== exp_rsp)
            $display("FAIL rsp_r: got %b want %b t=%0t", RSP_R, exp_rsp, $time);
         else passed++;
         if (exp_rsp != '0) begin
            total++;
            if (RSP_D !== ~exp_d)
               $display("FAIL rsp_d: got %h want %h", RSP_D, ~exp_d);
            else passed++;
         end
      end
      total++;
      if (ERR !== exp_err)
         $display("FAIL err: got %b want %b t=%0t", ERR, exp_err, $time);
      else passed++;
      @(posedge CLK);
      if (EN) begin
         if (w >= 0) begin
            q.push_back('{w, REQ_D[w*N +: N], en_cnt});
            mptr = (w + 1) % P;
         end
         if (spur) exp_err = 1'b1;
         en_cnt++;
      end
      #1;
      if (w >= 0) REQ_R[w] = 1'b0;
   endtask

   task automatic idle(input int n);
      EN = 1'b1;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      #2;
      RST = 1'b1;
      #1;
      total++;
      if (ACK !== '0 || OP_R_IN !== 1'b0 || OP_D_IN !== '0 ||
          RSP_R !== '0 || ERR !== 1'b0)
         $display("FAIL async_rst: ack=%b r=%b d=%h rsp=%b err=%b",
                  ACK, OP_R_IN, OP_D_IN, RSP_R, ERR);
      else passed++;
      REQ_R = '0;
      q.delete();
      mptr = 0;
      exp_err = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if (ACK !== '0 || OP_R_IN !== 1'b0 || OP_D_IN !== '0 ||
          RSP_R !== '0 || ERR !== 1'b0 || OP_EN !== EN)
         $display("FAIL reset: ack=%b r=%b d=%h rsp=%b err=%b",
                  ACK, OP_R_IN, OP_D_IN, RSP_R, ERR);
      else passed++;
   endtask

   task automatic test_all_req();
      logic [P-1:0] seq [5];
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < P; i++) REQ_D[i*N +: N] = 16'h1000 + 16'(i);
      for (int s = 0; s < 5; s++) begin
         REQ_R = '1;
         #1;
         total++;
         if (ACK !== seq[s])
            $display("FAIL all_req_seq%0d: got %b want %b", s, ACK, seq[s]);
         else passed++;
         tick();
      end
      REQ_R = '0;
      idle(L + 3);
   endtask

   task automatic test_single();
      REQ_R = 4'b0010;
      REQ_D[1*N +: N] = 16'h00AB;
      #1;
      total++;
      if (ACK !== 4'b0010)
         $display("FAIL single_ack: got %b want 0010", ACK);
      else passed++;
      tick();
      total++;
      if (OP_R_IN !== 1'b1 || OP_D_IN !== 16'h00AB)
         $display("FAIL single_opin: got r=%b d=%h want r=1 d=00ab",
                  OP_R_IN, OP_D_IN);
      else passed++;
      idle(L + 3);
   endtask

   task automatic test_wrap();
      REQ_R = 4'b1000;
      REQ_D[3*N +: N] = 16'h3333;
      tick();
      REQ_R = 4'b1001;
      REQ_D[0*N +: N] = 16'h0F0F;
      REQ_D[3*N +: N] = 16'h3434;
      #1;
      total++;
      if (ACK !== 4'b0001)
         $display("FAIL wrap_ack: got %b want 0001", ACK);
      else passed++;
      tick();
      REQ_R[0] = 1'b1;
      #1;
      total++;
      if (ACK !== 4'b1000)
         $display("FAIL wrap_ptr1: got %b want 1000", ACK);
      else passed++;
      tick();
      tick();
      idle(L + 3);
   endtask

   task automatic test_stall();
      logic [N-1:0] hold_d;
      REQ_R = 4'b0100;
      REQ_D[2*N +: N] = 16'hBEEF;
      tick();
      hold_d = OP_D_IN;
      EN = 1'b0;
      REQ_R = 4'b1111;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (OP_R_IN !== 1'b1 || OP_D_IN !== hold_d || RSP_R !== '0)
            $display("FAIL stall_hold: r=%b d=%h rsp=%b want r=1 d=%h rsp=0",
                     OP_R_IN, OP_D_IN, RSP_R, hold_d);
         else passed++;
      end
      REQ_R = '0;
      idle(L + 4);
   endtask

   task automatic test_spurious();
      idle(L + 2);
      spur = 1'b1;
      tick();
      spur = 1'b0;
      total++;
      if (ERR !== 1'b1)
         $display("FAIL spur_err: got %b want 1", ERR);
      else passed++;
      idle(4);
      do_reset();
      total++;
      if (ERR !== 1'b0)
         $display("FAIL spur_clear: got %b want 0", ERR);
      else passed++;
   endtask

   task automatic test_reset_inflight();
      REQ_R = '1;
      for (int i = 0; i < P; i++) REQ_D[i*N +: N] = 16'(16'hA000 + i);
      for (int i = 0; i < 3; i++) begin
         REQ_R = '1;
         tick();
      end
      do_reset();
      idle(L + 4);
      REQ_R = '1;
      #1;
      total++;
      if (ACK !== 4'b0001)
         $display("FAIL rst_ptr: got %b want 0001", ACK);
      else passed++;
      tick();
      REQ_R = '0;
      idle(L + 3);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < P; i++) begin
            if (!REQ_R[i] && ($urandom % 3 == 0)) begin
               REQ_R[i] = 1'b1;
               REQ_D[i*N +: N] = 16'($urandom);
            end
         end
         EN = ($urandom % 8 != 0);
         tick();
      end
      idle(P + L + 4);
      total++;
      if (q.size() != 0 || REQ_R !== '0)
         $display("FAIL rand_drain: pending=%0d req=%b want 0", q.size(), REQ_R);
      else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      total = 0;
      passed = 0;
      mptr = 0;
      en_cnt = 0;
      exp_err = 1'b0;
      spur = 1'b0;
      EN = 1'b1;
      REQ_R = '0;
      REQ_D = '0;
      RST = 1'b1;
      #1;
      test_reset();
      @(posedge CLK);
      #1;
      RST = 1'b0;
      test_all_req();
      test_single();
      test_wrap();
      test_stall();
      test_spurious();
      test_reset_inflight();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
